// File: rtl/sysid_checker_pkg.sv
// rtl/sysid_checker_pkg.sv - shared states, word addresses and counter sizing for sysid_checker
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WT_ID,
        RD_TS,
        WT_TS,
        DONE
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    function automatic int counter_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sysid_checker_timer.sv
// rtl/sysid_checker_timer.sv - saturating up-counter with clear; expire flags the cycle that reaches LIMIT
module sysid_checker_timer
    import sysid_checker_pkg::*;
#(
    parameter int LIMIT = 15,
    parameter int WIDTH = counter_width(LIMIT)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] TOP  = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != TOP) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the cycle whose increment brings the count to LIMIT.
    assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - sysid read-and-compare master; SYSID_CHECKER_PERIODIC_EN adds periodic rechecks and mismatch_seen
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5593_D10E,
    parameter int          TIMEOUT_CYCLES     = 1024,
    parameter bit          AUTO_START         = 1'b1,
    parameter int          RECHECK_PERIOD     = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
`ifdef SYSID_CHECKER_PERIODIC_EN
    output logic [31:0] ts_value,
    output logic        mismatch_seen
`else
    output logic [31:0] ts_value
`endif
);

    if (TIMEOUT_CYCLES < 2 || RECHECK_PERIOD < 1) begin : g_bad_params
        $error("sysid_checker: TIMEOUT_CYCLES must be >= 2 and RECHECK_PERIOD >= 1");
    end

    state_t state;
    state_t state_next;
    logic   auto_pending;
    logic   fail_timeout;
    logic   tmo_expire;
    logic   tmo_clear;
    logic   recheck_expire;
    logic   enter_check;
    logic   enter_done;
    logic   id_capture;
    logic   ts_capture;
    logic   ts_ok_final;
    logic   pass_final;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            auto_pending <= AUTO_START;
        end else begin
            state        <= state_next;
            auto_pending <= 1'b0;
        end
    end

    always_comb begin
        state_next   = state;
        fail_timeout = 1'b0;
        busy         = 1'b0;
        avm_read     = 1'b0;
        avm_address  = ADDR_ID;
        case (state)
            IDLE: begin
                if (start || auto_pending) state_next = RD_ID;
            end
            RD_ID: begin
                busy     = 1'b1;
                avm_read = 1'b1;
                if (tmo_expire) begin
                    state_next   = DONE;
                    fail_timeout = 1'b1;
                end else if (!avm_waitrequest) begin
                    state_next = WT_ID;
                end
            end
            WT_ID: begin
                busy = 1'b1;
                if (avm_readdatavalid) begin
                    state_next = RD_TS;
                end else if (tmo_expire) begin
                    state_next   = DONE;
                    fail_timeout = 1'b1;
                end
            end
            RD_TS: begin
                busy        = 1'b1;
                avm_read    = 1'b1;
                avm_address = ADDR_TS;
                if (tmo_expire) begin
                    state_next   = DONE;
                    fail_timeout = 1'b1;
                end else if (!avm_waitrequest) begin
                    state_next = WT_TS;
                end
            end
            WT_TS: begin
                busy = 1'b1;
                if (avm_readdatavalid) begin
                    state_next = DONE;
                end else if (tmo_expire) begin
                    state_next   = DONE;
                    fail_timeout = 1'b1;
                end
            end
            DONE: begin
                if (start || recheck_expire) state_next = RD_ID;
            end
            default: state_next = IDLE;
        endcase
    end

    assign enter_check = (state_next == RD_ID) && (state != RD_ID);
    assign enter_done  = (state_next == DONE) && (state != DONE);
    assign tmo_clear   = enter_check || ((state_next == RD_TS) && (state != RD_TS));
    assign id_capture  = (state == WT_ID) && avm_readdatavalid;
    assign ts_capture  = (state == WT_TS) && avm_readdatavalid;

    // pass is decided on the DONE-entry edge, so fold in a timestamp compare landing that same cycle.
    assign ts_ok_final = ts_capture ? (avm_readdata == EXPECTED_TIMESTAMP) : ts_ok;
    assign pass_final  = !fail_timeout && id_ok && ts_ok_final;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if (enter_check) begin
                done    <= 1'b0;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                pass    <= 1'b0;
                timeout <= 1'b0;
            end
            if (id_capture) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (ts_capture) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            end
            if (enter_done) begin
                done    <= 1'b1;
                timeout <= fail_timeout;
                pass    <= pass_final;
            end
        end
    end

    sysid_checker_timer #(
        .LIMIT (TIMEOUT_CYCLES - 1),
        .WIDTH (counter_width(TIMEOUT_CYCLES))
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (busy),
        .expire (tmo_expire)
    );

`ifdef SYSID_CHECKER_PERIODIC_EN
    sysid_checker_timer #(
        .LIMIT (RECHECK_PERIOD),
        .WIDTH (counter_width(RECHECK_PERIOD))
    ) u_recheck (
        .clock  (clock),
        .reset  (reset),
        .clear  (enter_done),
        .enable (state == DONE),
        .expire (recheck_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mismatch_seen <= 1'b0;
        end else if (enter_done && !pass_final) begin
            mismatch_seen <= 1'b1;
        end
    end
`else
    assign recheck_expire = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - randomized self-checking bench for sysid_checker with a behavioural sysid slave
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h5593_D10E;
    localparam int          TMO    = 16;
    localparam int          PERIOD = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, id_ok, ts_ok, pass, timeout;
    logic [31:0] id_value, ts_value;
`ifdef SYSID_CHECKER_PERIODIC_EN
    logic        mismatch_seen;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration and observations
    logic [31:0] slv_id = EXP_ID;
    logic [31:0] slv_ts = EXP_TS;
    int          cfg_wait_id = 0, cfg_wait_ts = 0, cfg_lat = 1;
    bit          mute_id = 0, mute_ts = 0;
    int          accepts = 0;
    bit          unstable = 0;

    always #5 clock = ~clock;

    sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (TMO),
        .AUTO_START         (1'b1),
        .RECHECK_PERIOD     (PERIOD)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .pass              (pass),
        .timeout           (timeout),
        .id_value          (id_value),
`ifdef SYSID_CHECKER_PERIODIC_EN
        .ts_value          (ts_value),
        .mismatch_seen     (mismatch_seen)
`else
        .ts_value          (ts_value)
`endif
    );

    // Behavioural sysid slave: per-read stall, fixed response latency, optional silence.
    initial begin : slave
        bit   in_read;
        logic in_addr;
        int   wait_left;
        int   pend_cnt;
        logic pend_addr;
        in_read = 0; in_addr = 0; wait_left = 0; pend_cnt = 0; pend_addr = 0;
        forever begin
            @(negedge clock);
            avm_readdatavalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0 && !(pend_addr ? mute_ts : mute_id)) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = pend_addr ? slv_ts : slv_id;
                end
            end
            if (reset) begin
                in_read = 0;
                avm_waitrequest = 1'b0;
            end else if (avm_read) begin
                if (!in_read) begin
                    in_read = 1;
                    in_addr = avm_address;
                    wait_left = avm_address ? cfg_wait_ts : cfg_wait_id;
                end else if (avm_address !== in_addr) begin
                    unstable = 1;
                end
                if (wait_left > 0) begin
                    avm_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_read = 0;
                    accepts++;
                    pend_cnt = cfg_lat;
                    pend_addr = in_addr;
                end
            end else begin
                if (in_read) unstable = 1;
                avm_waitrequest = 1'b0;
            end
        end
    end

    task automatic hold_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Release reset on a falling edge and count rising edges until done (auto-start).
    task automatic release_wait_done(output int cyc);
        reset = 1'b0;
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
        end while (!done && cyc < 400);
    endtask

    // Pulse start; cyc=1 is the first cycle after the start edge. spur>0 re-pulses start while busy.
    task automatic run_check(input int spur, output int cyc);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (cyc == spur) start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        hold_reset();
        n_cmp++; if ({avm_read, avm_address, busy, done, id_ok, ts_ok, pass, timeout} !== 8'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000000", {avm_read, avm_address, busy, done, id_ok, ts_ok, pass, timeout}); end
        n_cmp++; if (id_value !== 32'h0) begin n_bad++; $display("FAIL reset_id_value: got %h want 0", id_value); end
        n_cmp++; if (ts_value !== 32'h0) begin n_bad++; $display("FAIL reset_ts_value: got %h want 0", ts_value); end
`ifdef SYSID_CHECKER_PERIODIC_EN
        n_cmp++; if (mismatch_seen !== 1'b0) begin n_bad++; $display("FAIL reset_mismatch_seen: got %b want 0", mismatch_seen); end
`endif
    endtask

    task automatic test_auto_start();
        int cyc;
        slv_id = EXP_ID; slv_ts = EXP_TS;
        accepts = 0; unstable = 0;
        release_wait_done(cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL auto_latency: got %0d want 5", cyc); end
        n_cmp++; if ({id_ok, ts_ok, timeout, pass} !== 4'b1101) begin n_bad++; $display("FAIL auto_status: got %b want 1101", {id_ok, ts_ok, timeout, pass}); end
        n_cmp++; if (accepts !== 2) begin n_bad++; $display("FAIL auto_reads: got %0d want 2", accepts); end
        n_cmp++; if (ts_value !== EXP_TS) begin n_bad++; $display("FAIL auto_ts_value: got %h want %h", ts_value, EXP_TS); end
        n_cmp++; if (busy !== 1'b0 || avm_read !== 1'b0) begin n_bad++; $display("FAIL auto_idle_bus: got busy=%b read=%b want 0 0", busy, avm_read); end
    endtask

    task automatic test_id_mismatch();
        int cyc;
        slv_id = 32'h0000_0001;
        run_check(0, cyc);
        n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL idmis_latency: got %0d want 5", cyc); end
        n_cmp++; if ({id_ok, ts_ok, timeout, pass} !== 4'b0100) begin n_bad++; $display("FAIL idmis_status: got %b want 0100", {id_ok, ts_ok, timeout, pass}); end
        n_cmp++; if (id_value !== 32'h0000_0001) begin n_bad++; $display("FAIL idmis_id_value: got %h want 00000001", id_value); end
        slv_id = EXP_ID;
    endtask

    task automatic test_waitrequest();
        int cyc;
        cfg_wait_id = 3; cfg_wait_ts = 3;
        accepts = 0; unstable = 0;
        run_check(0, cyc);
        n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL wait_latency: got %0d want 11", cyc); end
        n_cmp++; if (unstable !== 1'b0) begin n_bad++; $display("FAIL wait_stable: got unstable=%b want 0", unstable); end
        n_cmp++; if (accepts !== 2) begin n_bad++; $display("FAIL wait_reads: got %0d want 2", accepts); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL wait_pass: got %b want 1", pass); end
        cfg_wait_id = 0; cfg_wait_ts = 0;
    endtask

    task automatic test_timeout();
        int cyc;
        mute_id = 1;
        run_check(0, cyc);
        n_cmp++; if (cyc !== TMO) begin n_bad++; $display("FAIL tmo_latency: got %0d want %0d", cyc, TMO); end
        n_cmp++; if ({done, timeout, pass, id_ok, ts_ok} !== 5'b11000) begin n_bad++; $display("FAIL tmo_status: got %b want 11000", {done, timeout, pass, id_ok, ts_ok}); end
        n_cmp++; if (avm_read !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL tmo_bus: got read=%b busy=%b want 0 0", avm_read, busy); end
        n_cmp++; if (id_value !== EXP_ID) begin n_bad++; $display("FAIL tmo_id_hold: got %h want %h", id_value, EXP_ID); end
        mute_id = 0;
    endtask

    task automatic test_reset_mid_check();
        int cyc;
        hold_reset();
        cfg_lat = 6;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++; if ({avm_read, avm_address, busy, done, id_ok, ts_ok, pass, timeout} !== 8'b0) begin n_bad++; $display("FAIL midrst_flags: got %b want 00000000", {avm_read, avm_address, busy, done, id_ok, ts_ok, pass, timeout}); end
        repeat (4) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (ts_value !== 32'h0) begin n_bad++; $display("FAIL midrst_late_data: got %h want 0", ts_value); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_restart: got busy=%b want 1", busy); end
        cyc = 0;
        while (!done && cyc < 400) begin @(posedge clock); #1; cyc++; end
        n_cmp++; if ({done, pass} !== 2'b11 || ts_value !== EXP_TS) begin n_bad++; $display("FAIL midrst_recheck: got done=%b pass=%b ts=%h want 1 1 %h", done, pass, ts_value, EXP_TS); end
        cfg_lat = 1;
    endtask

    task automatic test_random();
        int cyc, e_cyc, len_id, e_acc, spur;
        bit e_id_ok, e_ts_ok, e_to, e_pass;
        logic [31:0] m_id, m_ts;
        hold_reset();
        slv_id = EXP_ID; slv_ts = EXP_TS;
        release_wait_done(cyc);
        m_id = EXP_ID; m_ts = EXP_TS;
        for (int it = 0; it < 25; it++) begin
            slv_id = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            slv_ts = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            cfg_wait_id = $urandom_range(0, 4);
            cfg_wait_ts = $urandom_range(0, 4);
            cfg_lat = $urandom_range(1, 3);
            case ($urandom_range(0, 7))
                0: mute_id = 1;
                1: mute_ts = 1;
                default: ;
            endcase
            spur = ($urandom_range(0, 1) == 0) ? 2 : 0;
            if (mute_id) begin
                e_cyc = TMO; e_acc = 1;
                e_id_ok = 0; e_ts_ok = 0; e_to = 1;
            end else begin
                len_id = cfg_wait_id + 1 + cfg_lat;
                m_id = slv_id; e_id_ok = (slv_id == EXP_ID); e_acc = 2;
                if (mute_ts) begin
                    e_cyc = len_id + TMO; e_ts_ok = 0; e_to = 1;
                end else begin
                    e_cyc = 1 + len_id + cfg_wait_ts + 1 + cfg_lat;
                    m_ts = slv_ts; e_ts_ok = (slv_ts == EXP_TS); e_to = 0;
                end
            end
            e_pass = !e_to && e_id_ok && e_ts_ok;
            accepts = 0;
            run_check(spur, cyc);
            n_cmp++; if (cyc !== e_cyc) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", it, cyc, e_cyc); end
            n_cmp++; if ({id_ok, ts_ok, timeout, pass} !== {e_id_ok, e_ts_ok, e_to, e_pass}) begin n_bad++; $display("FAIL rand%0d_status: got %b want %b", it, {id_ok, ts_ok, timeout, pass}, {e_id_ok, e_ts_ok, e_to, e_pass}); end
            n_cmp++; if (id_value !== m_id || ts_value !== m_ts) begin n_bad++; $display("FAIL rand%0d_values: got %h/%h want %h/%h", it, id_value, ts_value, m_id, m_ts); end
            n_cmp++; if (accepts !== e_acc) begin n_bad++; $display("FAIL rand%0d_reads: got %0d want %0d", it, accepts, e_acc); end
            mute_id = 0; mute_ts = 0;
        end
        cfg_wait_id = 0; cfg_wait_ts = 0; cfg_lat = 1;
        slv_id = EXP_ID; slv_ts = EXP_TS;
    endtask

`ifdef SYSID_CHECKER_PERIODIC_EN
    task automatic test_periodic();
        int cyc, n;
        hold_reset();
        release_wait_done(cyc);
        n_cmp++; if (mismatch_seen !== 1'b0 || pass !== 1'b1) begin n_bad++; $display("FAIL per_first: got mismatch=%b pass=%b want 0 1", mismatch_seen, pass); end
        slv_id = 32'h0000_0001;
        n = 0;
        while (!busy && n < 300) begin @(posedge clock); #1; n++; end
        n_cmp++; if (n !== PERIOD) begin n_bad++; $display("FAIL per_interval: got %0d want %0d", n, PERIOD); end
        n = 0;
        while (!done && n < 300) begin @(posedge clock); #1; n++; end
        n_cmp++; if ({id_ok, pass, mismatch_seen} !== 3'b001) begin n_bad++; $display("FAIL per_second: got %b want 001", {id_ok, pass, mismatch_seen}); end
        slv_id = EXP_ID;
        n = 0;
        while (!busy && n < 300) begin @(posedge clock); #1; n++; end
        while (!done && n < 600) begin @(posedge clock); #1; n++; end
        n_cmp++; if ({pass, mismatch_seen} !== 2'b11) begin n_bad++; $display("FAIL per_sticky: got %b want 11", {pass, mismatch_seen}); end
    endtask
`endif

    initial begin
        test_reset();
        test_auto_start();
        test_id_mismatch();
        test_waitrequest();
        test_timeout();
        test_reset_mid_check();
        test_random();
`ifdef SYSID_CHECKER_PERIODIC_EN
        test_periodic();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that queries the system-ID slave and checks the two words it returns: word 0 is the system ID and word 1 is the build timestamp.
- Compares both words against the values compiled in at build time.
- Raises pass, fail and timeout status for boot firmware, the status LEDs and the reset sequencer.
- Sits on the Qsys control fabric next to the sysid slave and is clocked from the same control clock.

Parameters:
EXPECTED_ID, 32'h0000_0000, system ID value the build expects to read at slave word 0
EXPECTED_TIMESTAMP, 32'h5593_D10E, build timestamp the build expects to read at slave word 1
TIMEOUT_CYCLES, 1024, maximum cycles allowed per read, measured from read assertion to readdatavalid
AUTO_START, 1, 1 = start a check automatically in the first cycle after reset is released
RECHECK_PERIOD, 65536, idle cycles between automatic re-checks (used only with the optional feature)

Ports:
clock  in  1  control clock
reset  in  1  reset; asynchronous assertion, active-high
start  in  1  one-cycle request to begin a check; ignored while busy
avm_address  out  1  slave word select: 0 = ID, 1 = timestamp
avm_read  out  1  Avalon read strobe
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data qualifier
busy  out  1  a check is in progress
done  out  1  level; set when a check completes
id_ok  out  1  captured ID equals EXPECTED_ID
ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
pass  out  1  done & id_ok & ts_ok & !timeout
timeout  out  1  a read exceeded TIMEOUT_CYCLES
id_value  out  32  last captured ID word
ts_value  out  32  last captured timestamp word

Behaviour:
- Reset values: every output is 0, avm_read=0, avm_address=0, state=IDLE, timeout counter=0.
- States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE.
- IDLE -> RD_ID on start, or on the first cycle after reset release when AUTO_START=1.
  - Entering RD_ID clears done, id_ok, ts_ok and timeout.
  - id_value and ts_value are not cleared; they keep the last captured words.
- RD_ID: drive avm_read=1, avm_address=0, both held stable while avm_waitrequest=1.
  - Go to WT_ID in the cycle after a cycle with avm_waitrequest=0.
  - avm_read is deasserted in WT_ID; exactly one read is issued per word.
- WT_ID: on avm_readdatavalid, capture avm_readdata into id_value and register the ID compare into id_ok, then go to RD_TS.
  - A readdatavalid seen in any state other than WT_ID or WT_TS is ignored.
- RD_TS and WT_TS: same as RD_ID and WT_ID with avm_address=1; capture into ts_value and ts_ok, then go to DONE.
- DONE: done=1, busy=0. A start input restarts the check (DONE -> RD_ID).
- busy=1 in RD_ID, WT_ID, RD_TS and WT_TS. A start input while busy is ignored.
- pass is registered; it is valid from the same cycle that done rises.
- Timeout counter:
  - Clears on entry to RD_ID and on entry to RD_TS.
  - Increments every cycle in the four read states, saturating.
  - When the count reaches TIMEOUT_CYCLES-1 without the awaited data: deassert avm_read, set timeout=1, go straight to DONE (pass=0). id_ok and ts_ok keep their cleared or captured values.
- Latency with a zero-wait slave and readdatavalid one cycle after acceptance:
  - Start accepted at cycle 0 -> done=1 at cycle 5.
  - With AUTO_START, done=1 five cycles after reset deasserts.
- Reset asserted mid-check aborts immediately to the reset values; an outstanding read response arriving afterwards is ignored.

Optional Feature:
- Macro: SYSID_CHECKER_PERIODIC_EN.
- Defined:
  - After each DONE, a RECHECK_PERIOD down-counter runs; on expiry the FSM re-enters RD_ID automatically.
  - An added sticky output mismatch_seen latches when any completed check has pass=0, including timeouts. It is cleared only by reset.
- Undefined: no down-counter and no mismatch_seen port; the block checks only on start or auto-start.

Decomposition:
- Package sysid_checker_pkg holds:
  - the state enum;
  - the word-address constants ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - the function for the timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- One natural sub-module, sysid_checker_timer: a saturating counter with clear and an expiry flag. It is instantiated once for the timeout and, under the macro, once for the recheck period.

Test Plan:
- Zero-wait slave returning 0 then 32'h5593D10E; AUTO_START=1 -> done=1 at cycle 5 after reset release, pass=1, id_ok=1, ts_ok=1, exactly two reads issued.
- Slave returns ID 32'h00000001 -> id_ok=0, ts_ok=1, pass=0, id_value=32'h00000001.
- avm_waitrequest held for 3 cycles on each read -> avm_address and avm_read stay stable throughout; done arrives 6 cycles later than the zero-wait case; pass=1.
- readdatavalid never returned, TIMEOUT_CYCLES=16 -> timeout=1 at the 16th cycle of RD_ID/WT_ID, done=1, pass=0, avm_read=0.
- Reset pulsed while in WT_TS, then a late readdatavalid -> all outputs 0; the late data does not update ts_value; a new check runs after release.
- Macro defined, RECHECK_PERIOD=100, slave changes ID after the first check -> a second check starts 100 cycles after done; mismatch_seen=1 and stays set.
